// File: rtl/uart_arb_pkg.sv
// Shared types and default register map for the UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPollSetup,
    StPollAccess,
    StWrSetup,
    StWrAccess
  } state_e;

  localparam logic [31:0] TxdataAddrDefault = 32'h0000_0000;
  localparam logic [31:0] StatusAddrDefault = 32'h0000_0008;
  localparam int unsigned TxFifoFullBit     = 0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// APB bus bundle between the TX arbiter (master) and the UART register block (slave).
interface uart_tx_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned apb_dataW  = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [apb_dataW-1:0]  PWDATA;
  logic [apb_dataW-1:0]  PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the last granted index.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o
);

  always_comb begin
    logic found;
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(last_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N byte requesters onto a UART TX register over APB.
// Define UART_TXARB_POLL_EN to poll the status register (tx_fifo_full) before each write.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned          N_REQ       = 4,
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          apb_dataW   = 32,
  parameter logic [ADDR_WIDTH-1:0] TXDATA_ADDR = ADDR_WIDTH'(TxdataAddrDefault),
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(StatusAddrDefault)
) (
  input  logic                        PCLK,
  input  logic                        PRSTn,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic                        err,
  output logic                        busy,
  uart_tx_arbiter_if.master           apb
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  err_q, err_d;

  logic [N_REQ-1:0]      rr_gnt;
  logic [IdxW-1:0]       rr_idx;
  logic                  unused_prdata;

  assign unused_prdata = ^apb.PRDATA;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_rr_arbiter (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rr_gnt[i]) rr_idx = IdxW'(i);
    end
  end

  always_ff @(posedge PCLK or negedge PRSTn) begin
    if (!PRSTn) begin
      state_q <= StIdle;
      win_q   <= '0;
      last_q  <= IdxW'(N_REQ - 1);
      byte_q  <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    byte_d  = byte_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          win_d  = rr_idx;
          byte_d = req_data[32'(rr_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef UART_TXARB_POLL_EN
          state_d = StPollSetup;
`else
          state_d = StWrSetup;
`endif
        end
      end
      StPollSetup: state_d = StPollAccess;
      StPollAccess: begin
        if (apb.PREADY) state_d = apb.PRDATA[TxFifoFullBit] ? StPollSetup : StWrSetup;
      end
      StWrSetup: state_d = StWrAccess;
      StWrAccess: begin
        if (apb.PREADY) begin
`ifdef UART_TXARB_POLL_EN
          gnt_d[win_q] = 1'b1;
          err_d        = apb.PSLVERR;
          last_d       = win_q;
          state_d      = StIdle;
`else
          // Without polling, PSLVERR means the FIFO was full: rewrite the same byte.
          if (apb.PSLVERR) begin
            state_d = StWrSetup;
          end else begin
            gnt_d[win_q] = 1'b1;
            last_d       = win_q;
            state_d      = StIdle;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    unique case (state_q)
      StPollSetup, StPollAccess: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state_q == StPollAccess);
        apb.PADDR   = STATUS_ADDR;
      end
      StWrSetup, StWrAccess: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state_q == StWrAccess);
        apb.PWRITE  = 1'b1;
        apb.PADDR   = TXDATA_ADDR;
        apb.PWDATA  = apb_dataW'(byte_q);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign gnt  = gnt_q;
  assign err  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int PW = 32;
  localparam logic [AW-1:0] TxA = 32'h0000_0000;
  localparam logic [AW-1:0] StA = 32'h0000_0008;
`ifdef UART_TXARB_POLL_EN
  localparam bit PollEn = 1'b1;
`else
  localparam bit PollEn = 1'b0;
`endif

  logic            PCLK = 1'b0;
  logic            PRSTn;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            err;
  logic            busy;

  uart_tx_arbiter_if #(.ADDR_WIDTH(AW), .apb_dataW(PW)) apb ();

  uart_tx_arbiter #(
    .N_REQ       (N),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .apb_dataW   (PW),
    .TXDATA_ADDR (TxA),
    .STATUS_ADDR (StA)
  ) dut (
    .PCLK     (PCLK),
    .PRSTn    (PRSTn),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .err      (err),
    .busy     (busy),
    .apb      (apb)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by winner, byte and cost so far.
  bit          pend;
  int          win, last, cyc, start_cyc, cost, gnt_due, wait_left, cur_waits;
  logic [DW-1:0] exp_byte;
  bit          exp_err, wr_ok;
  bit          p_setup, p_wait, p_write;
  logic [AW-1:0] p_addr;
  logic [PW-1:0] p_wdata;
  int          full_pct, err_pct, max_wait, req_pct, hold_pct, scr_pct;

  task automatic set_knobs(input int f, input int e, input int w, input int r, input int h,
                           input int s);
    full_pct = f; err_pct = e; max_wait = w; req_pct = r; hold_pct = h; scr_pct = s;
  endtask

  task automatic model_arb();
    bit found;
    found = 1'b0;
    if (!pend && req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (!found && req[j]) begin
          win   = j;
          found = 1'b1;
        end
      end
      pend      = 1'b1;
      exp_byte  = req_data[win*DW +: DW];
      start_cyc = cyc;
      cost      = 0;
      wr_ok     = !PollEn;
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_gnt;
    logic         exp_e;
    bit           ready;
    @(negedge PCLK);
    cyc++;
    exp_gnt = '0;
    exp_e   = 1'b0;
    if (cyc == gnt_due) begin
      exp_gnt[win] = 1'b1;
      exp_e        = exp_err;
      check_eq("latency", cyc - start_cyc, cost + 1);
      pend = 1'b0;
      last = win;
    end
    check_eq("gnt", gnt, exp_gnt);
    check_eq("err", err, exp_e);
    check_eq("busy", busy, pend);
    if (pend && (cyc - start_cyc) > 500) begin
      check_eq("stall", cyc - start_cyc, 0);
      pend = 1'b0;
    end

    if (p_setup || p_wait) begin
      check_eq("hold", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA},
               {2'b11, p_write, p_addr, p_wdata});
    end else if (apb.PSEL) begin
      check_eq("setup_phase", apb.PENABLE, 1'b0);
      check_eq("xfer_pend", pend, 1'b1);
      check_eq("setup_sig", {apb.PWRITE, apb.PADDR, apb.PWDATA},
               {wr_ok, wr_ok ? TxA : StA, wr_ok ? PW'(exp_byte) : PW'(0)});
    end else begin
      check_eq("idle_bus", {apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA}, '0);
    end

    ready = 1'b0;
    if (apb.PSEL && apb.PENABLE) begin
      if (p_setup) begin
        cur_waits = (max_wait > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, max_wait) : 0;
        wait_left = cur_waits;
      end
      ready = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      ready = $urandom_range(0, 1) == 1;
    end
    apb.PREADY  = ready;
    apb.PRDATA  = $urandom;
    apb.PSLVERR = $urandom_range(0, 1) == 1;
    if (apb.PSEL && apb.PENABLE && ready) begin
      cost += 2 + cur_waits;
      if (!wr_ok) begin
        apb.PSLVERR   = 1'b0;
        apb.PRDATA[0] = $urandom_range(1, 100) <= full_pct;
        if (!apb.PRDATA[0]) wr_ok = 1'b1;
      end else begin
        apb.PSLVERR = $urandom_range(1, 100) <= err_pct;
        if (PollEn || !apb.PSLVERR) begin
          gnt_due = cyc + 1;
          exp_err = PollEn && apb.PSLVERR;
        end
      end
    end
    p_setup = apb.PSEL && !apb.PENABLE;
    p_wait  = apb.PSEL && apb.PENABLE && !ready;
    p_write = apb.PWRITE;
    p_addr  = apb.PADDR;
    p_wdata = apb.PWDATA;

    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        if ($urandom_range(1, 100) <= hold_pct) req_data[i*DW +: DW] = DW'($urandom);
        else req[i] = 1'b0;
      end else if (!req[i] && $urandom_range(1, 100) <= req_pct) begin
        req[i]               = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end else if (pend && i == win && $urandom_range(1, 100) <= scr_pct) begin
        req_data[i*DW +: DW] = DW'($urandom);
        if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
      end
    end
    model_arb();
  endtask

  task automatic do_reset();
    #1 PRSTn = 1'b0;
    #1 check_eq("rst_outputs",
                {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, gnt, err, busy}, '0);
    req = '1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    repeat (2) @(negedge PCLK);
    PRSTn     = 1'b1;
    pend      = 1'b0;
    last      = N - 1;
    gnt_due   = -1;
    p_setup   = 1'b0;
    p_wait    = 1'b0;
    wait_left = 0;
    cur_waits = 0;
    model_arb();
  endtask

  initial begin
    bit found;
    PRSTn       = 1'b0;
    req         = '0;
    req_data    = '0;
    apb.PREADY  = 1'b0;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    cyc         = 0;
    pend        = 1'b0;
    gnt_due     = -1;
    set_knobs(0, 0, 0, 0, 100, 0);
    do_reset();
    repeat (40) step();

    set_knobs(30, 20, 3, 20, 30, 10);
    repeat (3000) step();
    set_knobs(40, 10, 6, 50, 50, 20);
    repeat (1000) step();

    set_knobs(0, 0, 6, 50, 50, 0);
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      step();
      if (apb.PSEL && apb.PENABLE && apb.PWRITE) found = 1'b1;
    end
    check_eq("find_wr_access", found, 1'b1);
    set_knobs(0, 0, 0, 0, 100, 0);
    do_reset();
    repeat (40) step();
    set_knobs(30, 20, 3, 20, 30, 10);
    repeat (500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
